sample_pacer: RTL
=================

Name: sample_pacer

Overview:
- Schedules sample delivery into the pwmer/SDM modulator datapath.
- Accepts signed samples from an upstream source over a valid/ready handshake and buffers them in a small FIFO.
- Releases exactly one sample every FDIV clocks on dout/dout_stb, replacing the fixed-rate stimulus loop with synthesizable pacing.
- Handles start-up prefill, enable/disable and underrun.

Parameters:
- N, 8: sample width, signed two's complement.
- FDIV, 50: clocks per output sample; must be >= 2.
- AW, 4: FIFO address width; depth = 2^AW.
- PREFILL, 8: FIFO level required to start or resume; must satisfy 1 <= PREFILL <= 2^AW.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- areset  in  1  reset; synchronous, active-high.
- en  in  1  pacing enable.
- clr_stat  in  1  clears the sticky underrun flag.
- s_data  in  N  upstream sample, signed.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  FIFO can accept; equals !full.
- dout  out  N  sample to modulator (pwmer din); held between strobes.
- dout_stb  out  1  one-cycle pulse, asserted in the cycle dout takes a new value.
- running  out  1  high in RUN state.
- underrun  out  1  sticky; set when a tick finds the FIFO empty.
- level  out  AW+1  current FIFO occupancy, 0..2^AW.

Behaviour:
- Reset (areset=1 at a clock edge):
  - Outputs: dout=0, dout_stb=0, running=0, underrun=0, level=0.
  - Internal: FIFO emptied, state=IDLE, cnt=0.
  - Reset mid-operation discards all buffered samples.
- Push rule:
  - A sample is written when s_valid && s_ready.
  - s_ready is combinational !full. It stays low when full even if a pop occurs in the same cycle.
  - level reflects the write one cycle later.
- Pop/push in the same cycle (FIFO not full): both take effect, so level is unchanged.
- States:
  - IDLE: cnt held at 0, no ticks. Go to RUN when en && level >= PREFILL.
  - RUN: cnt counts 0..FDIV-1 and wraps. tick = (cnt==0). The first tick occurs in the first RUN cycle.
    - On a tick with the FIFO non-empty: pop the head, and at the next edge dout <= head, dout_stb=1.
    - On a tick with the FIFO empty: dout <= 0, dout_stb=1, underrun <= 1, state <= UNDERRUN.
  - UNDERRUN: cnt keeps running, so cadence is unchanged.
    - Each tick drives dout <= 0 with dout_stb=1.
    - When level >= PREFILL is seen at a tick, that tick pops normally and the state returns to RUN. Resumption happens only on tick boundaries.
  - Any state, en=0: next state IDLE, cnt <= 0, dout <= 0 with no strobe, FIFO contents kept.
- Strobe spacing: exactly FDIV cycles apart during RUN and UNDERRUN.
- Latency: from the first IDLE->RUN transition edge, dout_stb is seen 1 cycle later.
- underrun:
  - Set-dominant over clr_stat when both occur in the same cycle.
  - Otherwise clr_stat=1 clears it at the next edge.
- running=1 only in RUN; it is 0 in UNDERRUN.
- Arithmetic and pointers:
  - FIFO pointers are AW+1 bits; full/empty are derived from the MSB compare.
  - Pointers wrap modulo 2^(AW+1).
  - Samples pass through unmodified; no sign extension or truncation.

Optional Feature:
- Macro: SAMPLE_PACER_HOLD_LAST_EN.
- Defined: on an underrun tick, dout re-presents the last successfully popped sample (0 if none since reset), still with dout_stb=1.
- Undefined: underrun ticks drive dout=0 (mid-scale for a signed DAC).
- en=0 still forces dout=0 in both builds.

Decomposition:
- Package sdm_pkg:
  - State enum: IDLE, RUN, UNDERRUN.
  - Localparams: DEPTH = 2^AW, counter width $clog2(FDIV).
- Natural sub-module: sync_fifo (parameters N, AW).
  - Ports: push, pop, din, dout, full, empty, level.
  - Synchronous active-high reset.
  - First-word-fall-through head, so a tick pops and captures in one cycle.
- sample_pacer contains the FSM, the tick counter and the dout register.

Test Plan:
- Start-up: push 0x01..0x08 with en=1, FDIV=50, PREFILL=8.
  - RUN entered the cycle after level=8.
  - dout = 0x01, 0x02, … with strobes exactly 50 cycles apart.
- Backpressure: push 20 samples with en=0 and AW=4.
  - s_ready drops after 16; level=16; samples 17-20 are not accepted.
  - Raise en: outputs are samples 1..16 in order.
- Underrun: prefill 8, then stop pushing.
  - After the 8th sample, the next strobe gives dout=0 and underrun=1.
  - Refill to 8: RUN resumes on a tick and strobe spacing stays 50.
- Sticky/clear: while underrun=1, pulse clr_stat on the same cycle as a new underrun tick -> underrun stays 1. clr_stat alone later -> underrun=0 next cycle.
- Reset mid-RUN: assert areset with level=5 and dout=0x7F.
  - Next cycle: dout=0, level=0, running=0, no strobe until PREFILL is reached again.
- Build with SAMPLE_PACER_HOLD_LAST_EN: last sample 0x80 (-128) before underrun -> underrun strobes carry 0x80 instead of 0.

Source files
------------

// File: rtl/sdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdm_pkg
// Brief    : Shared state encoding and sizing helpers for the sample pacer.
// Revision : 1.0
// ============================================================================
package sdm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        UNDERRUN = 2'd2
    } pacer_state_e;

    localparam int DEF_AW   = 4;
    localparam int DEF_FDIV = 50;
    localparam int DEPTH    = 2 ** DEF_AW;
    localparam int CNT_W    = $clog2(DEF_FDIV);

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic int cnt_width(input int fdiv);
        return (fdiv > 1) ? $clog2(fdiv) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_pacer_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_pacer_if
// Brief    : Upstream valid/ready sample stream feeding the pacer FIFO.
// Revision : 1.0
// ============================================================================
interface sample_pacer_if #(
    parameter int N = 8
);
    logic [N-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with first-word-fall-through head.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire logic [N-1:0] din,
    output logic      [N-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic      [AW:0]  level
);
    localparam int c_DEPTH = 2 ** AW;

    logic [N-1:0] r_mem [c_DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_push;
    logic         w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign empty  = (r_wr == r_rd);
    assign level  = r_wr - r_rd;
    assign dout   = r_mem[r_rd[AW-1:0]];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : sample_pacer
// Brief    : Buffers upstream samples and releases one every FDIV clocks.
//            Optional macro SAMPLE_PACER_HOLD_LAST_EN repeats the last sample
//            on underrun ticks instead of emitting zero.
// Revision : 1.0
// ============================================================================
module sample_pacer
    import sdm_pkg::*;
#(
    parameter int N       = 8,
    parameter int FDIV    = 50,
    parameter int AW      = 4,
    parameter int PREFILL = 8
) (
    input  wire logic          clk,
    input  wire logic          areset,
    input  wire logic          en,
    input  wire logic          clr_stat,
    sample_pacer_if.slave      s,
    output logic      [N-1:0]  dout,
    output logic               dout_stb,
    output logic               running,
    output logic               underrun,
    output logic      [AW:0]   level
);
    localparam int             c_CW          = cnt_width(FDIV);
    localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(FDIV - 1);
    localparam logic [AW:0]    c_PREFILL_LVL = (AW + 1)'(PREFILL);
    localparam logic [1:0]     c_ST_IDLE     = IDLE;
    localparam logic [1:0]     c_ST_RUN      = RUN;
    localparam logic [1:0]     c_ST_UNDER    = UNDERRUN;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [N-1:0]    r_dout;
    logic            r_stb;
    logic            r_underrun;

    logic            w_full;
    logic            w_empty;
    logic [AW:0]     w_level;
    logic [N-1:0]    w_head;
    logic [N-1:0]    w_fill;
    logic            w_tick;
    logic            w_lvl_ok;
    logic            w_pop;
    logic            w_starve;

    sync_fifo #(
        .N  (N),
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (areset),
        .push  (s.s_valid),
        .pop   (w_pop),
        .din   (s.s_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign s.s_ready = !w_full;
    assign w_tick    = (r_state != c_ST_IDLE) && (r_cnt == '0);
    assign w_lvl_ok  = (w_level >= c_PREFILL_LVL);
    // Resumption from underrun only on a tick and only once refilled to PREFILL.
    assign w_pop     = en && w_tick &&
                       (((r_state == c_ST_RUN) && !w_empty) ||
                        ((r_state == c_ST_UNDER) && w_lvl_ok));
    assign w_starve  = en && w_tick && w_empty;

`ifdef SAMPLE_PACER_HOLD_LAST_EN
    logic [N-1:0] r_last;

    always_ff @(posedge clk) begin
        if (areset)     r_last <= '0;
        else if (w_pop) r_last <= w_head;
    end

    assign w_fill = r_last;
`else
    assign w_fill = '0;
`endif

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_dout     <= '0;
            r_stb      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_stb <= 1'b0;

            if (w_starve)      r_underrun <= 1'b1;
            else if (clr_stat) r_underrun <= 1'b0;

            if (!en) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
                r_dout  <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_cnt <= '0;
                        if (w_lvl_ok) r_state <= c_ST_RUN;
                    end
                    default: begin
                        r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
                        if (w_tick) begin
                            r_stb <= 1'b1;
                            if (w_pop) begin
                                r_dout  <= w_head;
                                r_state <= c_ST_RUN;
                            end else begin
                                r_dout  <= w_fill;
                                r_state <= c_ST_UNDER;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign dout     = r_dout;
    assign dout_stb = r_stb;
    assign running  = (r_state == c_ST_RUN);
    assign underrun = r_underrun;
    assign level    = w_level;
endmodule
`default_nettype wire
